// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a PC-indexed table of 2-bit saturating
// counters for Fetch prediction, plus saturating branch/mispredict counters.
module branch_predict_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PC_F,
  output logic                  PredTaken_F,
  input  logic                  Valid_E,
  input  logic                  IsBranch_E,
  input  logic [2:0]            Branch_E,
  input  logic [1:0]            Jump_E,
  input  logic                  Zero_E,
  input  logic                  signedLess_E,
  input  logic                  unsignedLess_E,
  input  logic [ADDR_WIDTH-1:0] PC_E,
  input  logic                  PredTaken_E,
  output logic [2:0]            PCSrc_E,
  output logic                  Flush_E,
  output logic [CNT_W-1:0]      BranchCount,
  output logic [CNT_W-1:0]      MispredictCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] SRC_NONE    = 3'b000;
  localparam logic [2:0] SRC_BRANCH  = 3'b001;
  localparam logic [2:0] SRC_JAL     = 3'b010;
  localparam logic [2:0] SRC_JALR    = 3'b011;
  localparam logic [2:0] SRC_RECOVER = 3'b100;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             taken;
  logic             jump_active;
  logic             do_update;
  logic             unused_pc;

  assign idx_f = PC_F[IDX_W+1:2];
  assign idx_e = PC_E[IDX_W+1:2];
  assign unused_pc = ^{PC_F[ADDR_WIDTH-1:IDX_W+2], PC_F[1:0],
                       PC_E[ADDR_WIDTH-1:IDX_W+2], PC_E[1:0]};

  // Prediction is forced low during reset so stale history never leaks out.
  assign PredTaken_F = rst ? 1'b0 : bht[idx_f][1];

  always_comb begin
    taken = 1'b0;
    case (Branch_E)
      3'b000:  taken = Zero_E;
      3'b001:  taken = ~Zero_E;
      3'b100:  taken = signedLess_E;
      3'b101:  taken = ~signedLess_E;
      3'b110:  taken = unsignedLess_E;
      3'b111:  taken = ~unsignedLess_E;
      default: taken = 1'b0;
    endcase
  end

  // Jump_E of 10 (JAL) and 11 (JALR) both have the upper bit set.
  assign jump_active = Jump_E[1];
  assign do_update   = Valid_E & IsBranch_E & ~jump_active;

  always_comb begin
    PCSrc_E = SRC_NONE;
    if (Valid_E) begin
      if (Jump_E == 2'b10) begin
        PCSrc_E = SRC_JAL;
      end else if (Jump_E == 2'b11) begin
        PCSrc_E = SRC_JALR;
      end else if (IsBranch_E) begin
        if (taken && !PredTaken_E) begin
          PCSrc_E = SRC_BRANCH;
        end else if (!taken && PredTaken_E) begin
          PCSrc_E = SRC_RECOVER;
        end
      end
    end
  end

  assign Flush_E = (PCSrc_E != SRC_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      bht             <= '{default: 2'b01};
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (do_update) begin
      if (taken && bht[idx_e] != 2'b11) begin
        bht[idx_e] <= bht[idx_e] + 2'd1;
      end else if (!taken && bht[idx_e] != 2'b00) begin
        bht[idx_e] <= bht[idx_e] - 2'd1;
      end
      if (BranchCount != '1) begin
        BranchCount <= BranchCount + CNT_W'(1);
      end
      if ((taken != PredTaken_E) && (MispredictCount != '1)) begin
        MispredictCount <= MispredictCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver pushes model expectations,
// a monitor pops them on the falling edge and compares against the DUT.
module tb_branch_predict_unit;

  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] PC_F = '0;
  logic          PredTaken_F;
  logic          Valid_E = 1'b0;
  logic          IsBranch_E = 1'b0;
  logic [2:0]    Branch_E = '0;
  logic [1:0]    Jump_E = '0;
  logic          Zero_E = 1'b0;
  logic          signedLess_E = 1'b0;
  logic          unsignedLess_E = 1'b0;
  logic [AW-1:0] PC_E = '0;
  logic          PredTaken_E = 1'b0;
  logic [2:0]    PCSrc_E;
  logic          Flush_E;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] MispredictCount;

  branch_predict_unit #(.ADDR_WIDTH(AW), .BHT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .PC_F(PC_F), .PredTaken_F(PredTaken_F),
    .Valid_E(Valid_E), .IsBranch_E(IsBranch_E), .Branch_E(Branch_E),
    .Jump_E(Jump_E), .Zero_E(Zero_E), .signedLess_E(signedLess_E),
    .unsignedLess_E(unsignedLess_E), .PC_E(PC_E), .PredTaken_E(PredTaken_E),
    .PCSrc_E(PCSrc_E), .Flush_E(Flush_E), .BranchCount(BranchCount),
    .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] pcf;
    bit          valid;
    bit          isbr;
    logic [2:0]  f3;
    logic [1:0]  jmp;
    bit          zero;
    bit          sl;
    bit          ul;
    logic [31:0] pce;
    bit          pe;
  } stim_t;

  typedef struct {
    int pcsrc;
    int flush;
    int pred;
    bit chk_cnt;
    int bc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: counter values 0..3 per entry, plain integer counts.
  int   m_bht[DEPTH];
  int   m_bc = 0;
  int   m_mc = 0;
  bit   m_known = 1'b0;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit outcome(stim_t s);
    case (s.f3)
      3'b000:  return s.zero;
      3'b001:  return !s.zero;
      3'b100:  return s.sl;
      3'b101:  return !s.sl;
      3'b110:  return s.ul;
      3'b111:  return !s.ul;
      default: return 1'b0;
    endcase
  endfunction

  function automatic stim_t idle(logic [31:0] pcf);
    stim_t s;
    s = '{rst: 1'b0, pcf: pcf, valid: 1'b0, isbr: 1'b0, f3: 3'b000, jmp: 2'b00,
          zero: 1'b0, sl: 1'b0, ul: 1'b0, pce: 32'h0, pe: 1'b0};
    return s;
  endfunction

  function automatic stim_t branch(logic [31:0] pc, logic [2:0] f3, bit zero,
                                   bit sl, bit ul, bit pe);
    stim_t s;
    s = idle(pc);
    s.valid = 1'b1;
    s.isbr  = 1'b1;
    s.f3    = f3;
    s.zero  = zero;
    s.sl    = sl;
    s.ul    = ul;
    s.pce   = pc;
    s.pe    = pe;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   t;
    @(posedge clk);
    #1;
    rst = s.rst; PC_F = s.pcf; Valid_E = s.valid; IsBranch_E = s.isbr;
    Branch_E = s.f3; Jump_E = s.jmp; Zero_E = s.zero; signedLess_E = s.sl;
    unsignedLess_E = s.ul; PC_E = s.pce; PredTaken_E = s.pe;

    t = outcome(s);
    e.pcsrc = 0;
    if (s.valid) begin
      if (s.jmp == 2'b10) e.pcsrc = 2;
      else if (s.jmp == 2'b11) e.pcsrc = 3;
      else if (s.isbr) begin
        if (t && !s.pe) e.pcsrc = 1;
        else if (!t && s.pe) e.pcsrc = 4;
      end
    end
    e.flush   = (e.pcsrc != 0) ? 1 : 0;
    e.pred    = (s.rst || !m_known) ? 0 : (m_bht[idx_of(s.pcf)] >= 2 ? 1 : 0);
    e.chk_cnt = !s.rst && m_known;
    e.bc      = m_bc;
    e.mc      = m_mc;
    if (s.rst || m_known) exp_q.push_back(e);

    if (s.rst) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_bc = 0;
      m_mc = 0;
      m_known = 1'b1;
    end else if (s.valid && s.isbr && s.jmp != 2'b10 && s.jmp != 2'b11) begin
      int k;
      k = idx_of(s.pce);
      m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                   : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (t != s.pe) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("PCSrc_E", int'(PCSrc_E), e.pcsrc);
        checkOutput("Flush_E", int'(Flush_E), e.flush);
        checkOutput("PredTaken_F", int'(PredTaken_F), e.pred);
        if (e.chk_cnt) begin
          checkOutput("BranchCount", int'(BranchCount), e.bc);
          checkOutput("MispredictCount", int'(MispredictCount), e.mc);
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    foreach (m_bht[i]) m_bht[i] = 1;

    $display("[TB] reset and index sweep");
    s = idle(32'h0); s.rst = 1'b1; applyStimulus(s);
    for (int i = 0; i < DEPTH; i++) applyStimulus(idle(32'(i * 4)));

    $display("[TB] training BEQ at 0x40");
    applyStimulus(branch(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(branch(32'h40, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(idle(32'h40));

    $display("[TB] recovery");
    applyStimulus(branch(32'h40, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1));
    applyStimulus(branch(32'h40, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1));
    applyStimulus(idle(32'h40));

    $display("[TB] jump priority and bubbles");
    s = branch(32'h80, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1); s.jmp = 2'b11; applyStimulus(s);
    s = idle(32'h80); s.jmp = 2'b10; s.isbr = 1'b1; s.pe = 1'b1; applyStimulus(s);
    s = branch(32'h80, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0); s.valid = 1'b0; applyStimulus(s);
    s = branch(32'h80, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1); applyStimulus(s);
    applyStimulus(idle(32'h80));

    $display("[TB] saturation and no-bypass");
    for (int i = 0; i < 5; i++) applyStimulus(branch(32'h100, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1));
    applyStimulus(branch(32'h100, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1));
    applyStimulus(idle(32'h100));
    for (int i = 0; i < 20; i++) applyStimulus(branch(32'h200, 3'b111, 1'b0, 1'b0, 1'b0, i[0]));
    applyStimulus(idle(32'h200));

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(branch(32'h44, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0));
    s = idle(32'h44); s.rst = 1'b1; applyStimulus(s);
    applyStimulus(idle(32'h44));

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      s.rst   = ($urandom_range(0, 59) == 0);
      s.pcf   = {$urandom_range(0, 3), 24'h0, 2'($urandom_range(0, 3)), 4'h0, 2'($urandom)};
      s.pce   = {$urandom_range(0, 3), 24'h0, 2'($urandom_range(0, 3)), 4'h0, 2'($urandom)};
      s.valid = ($urandom_range(0, 7) != 0);
      s.isbr  = ($urandom_range(0, 3) != 0);
      s.f3    = 3'($urandom);
      s.jmp   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      s.zero  = 1'($urandom);
      s.sl    = 1'($urandom);
      s.ul    = 1'($urandom);
      s.pe    = 1'($urandom);
      applyStimulus(s);
    end

    repeat (20) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
